// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command sender: inhibits the bus, issues request-to-send and
// shifts one byte out on device-generated clock falls, then checks the device ack.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk_in,
    input  logic       kdata_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FILTER_LEN + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_REL
    } state_t;

    state_t        state;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          kclk_fall;
    logic          kclk_filt;
    logic          kdata_filt;
    logic [TW-1:0] timer;
    logic [9:0]    shift;
    logic [3:0]    bit_cnt;

    assign kclk_filt  = filt[0];
    assign kdata_filt = filt[1];

    // Index 0 is kclk, index 1 is kdata; a line only flips after FILTER_LEN
    // consecutive synced samples disagree with its current filtered value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 2'b11;
            sync_b    <= 2'b11;
            filt      <= 2'b11;
            kclk_fall <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            sync_a    <= {kdata_in, kclk_in};
            sync_b    <= sync_a;
            kclk_fall <= filt[0] & ~sync_b[0] & (fcnt[0] == F_LAST);
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == F_LAST) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            timer    <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift    <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt  <= '0;
                        timer    <= '0;
                        busy     <= 1'b1;
                        kclk_oe  <= 1'b1;
                        kdata_oe <= 1'b0;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == INH_LAST) begin
                        kdata_oe <= 1'b1;
                        state    <= RTS;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RTS: begin
                    kclk_oe <= 1'b0;
                    timer   <= '0;
                    state   <= SEND;
                end
                // The timeout window spans the whole device-clocked part of the frame.
                SEND, ACK, WAIT_REL: begin
                    timer <= timer + TW'(1);
                    if (timer == TO_LAST) begin
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (state == SEND) begin
                        if (kclk_fall) begin
                            kdata_oe <= ~shift[0];
                            shift    <= {1'b0, shift[9:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        if (kclk_fall) begin
                            if (!kdata_filt) begin
                                state <= WAIT_REL;
                            end else begin
                                kdata_oe <= 1'b0;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end else if (kclk_filt && kdata_filt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: an open-drain device model clocks frames out of the DUT while
// a per-cycle model of the transaction timeline checks every output on each falling edge.
module tb_ps2_transmitter;

    localparam int INH  = 100;
    localparam int TO   = 20000;
    localparam int FL   = 4;
    localparam int HALF = 200;
    localparam int TIMEOUT_AGE = INH + 2 + TO;

    logic       clk = 1'b0;
    logic       rst;
    logic       dev_clk;
    logic       dev_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       kclk_in;
    logic       kdata_in;
    logic       kclk_oe;
    logic       kdata_oe;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int passes = 0;

    bit m_busy = 1'b0;
    int m_age = 0;
    int outcome_seq = 0;
    int last_kind = 0;
    int last_age = 0;
    int inh_len = 0;
    int last_inh_len = 0;

    ps2_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kclk_in(kclk_in),
        .kdata_in(kdata_in),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .kclk_oe(kclk_oe),
        .kdata_oe(kdata_oe),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // Wired-AND bus: either side can pull a line low.
    assign kclk_in  = dev_clk & ~kclk_oe;
    assign kdata_in = dev_data & ~kdata_oe;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [10:0] expectedFrame(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) ones++;
        end
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    // Timeline model: cycles since accept decide what the outputs must be.
    always @(negedge clk) begin
        if (!m_busy) begin
            checkOutput("idle_outputs", 32'({kclk_oe, kdata_oe, busy, done, err}), 32'h0);
        end else if (m_age <= INH) begin
            checkOutput("inhibit_outputs", 32'({kclk_oe, kdata_oe, busy, done, err}), 32'b10100);
        end else if (m_age == INH + 1) begin
            checkOutput("rts_outputs", 32'({kclk_oe, kdata_oe, busy, done, err}), 32'b11100);
        end else if (done || err) begin
            checkOutput("end_pulse_outputs", 32'({kclk_oe, kdata_oe, busy, done & err}), 32'h0);
            if (m_age == TIMEOUT_AGE) checkOutput("timeout_is_err", 32'(err), 32'd1);
            last_kind = done ? 1 : 2;
            last_age  = m_age;
            outcome_seq++;
            m_busy = 1'b0;
        end else if (m_age >= TIMEOUT_AGE) begin
            checkOutput("timeout_err_missing", 32'(err), 32'd1);
            m_busy = 1'b0;
        end else begin
            checkOutput("send_outputs", 32'({kclk_oe, busy}), 32'b01);
        end

        if (kclk_oe && !kdata_oe) begin
            inh_len++;
        end else begin
            if (inh_len != 0) last_inh_len = inh_len;
            inh_len = 0;
        end

        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end else if (tx_start) begin
            m_busy = 1'b1;
            m_age  = 1;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        waitCycles(1);
        tx_start = 1'b0;
    endtask

    task automatic waitRts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 50; i++) begin
            if (busy && !kclk_oe && kdata_oe) begin
                ok = 1'b1;
                return;
            end
            waitCycles(1);
        end
        checkOutput("rts_reached", 32'd0, 32'd1);
    endtask

    // Device side: samples on rising edges, optionally acks on the 11th clock.
    task automatic devClockBits(input int nfalls, input bit ack, input bit glitch, output logic [10:0] frame);
        frame = '0;
        waitCycles(50);
        frame[0] = kdata_in;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk = 1'b0;
            waitCycles(HALF);
            dev_clk = 1'b1;
            frame[i] = kdata_in;
            if (glitch && i == 3) begin
                waitCycles(HALF / 2);
                dev_clk = 1'b0;
                waitCycles(2);
                dev_clk = 1'b1;
                waitCycles(HALF / 2 - 2);
            end else begin
                waitCycles(HALF);
            end
        end
        if (nfalls == 10) begin
            if (ack) dev_data = 1'b0;
            waitCycles(50);
            dev_clk = 1'b0;
            waitCycles(HALF);
            dev_clk = 1'b1;
            waitCycles(50);
            dev_data = 1'b1;
        end
    endtask

    task automatic waitOutcome(input int prev_seq, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (outcome_seq != prev_seq) return;
            waitCycles(1);
        end
        checkOutput("outcome_seen", 32'd0, 32'd1);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit ack, input bit glitch,
                            output logic [10:0] frame, output int kind);
        int seq;
        bit ok;
        seq = outcome_seq;
        frame = '0;
        applyStimulus(b);
        waitRts(ok);
        if (ok) devClockBits(10, ack, glitch, frame);
        waitOutcome(seq, 2000);
        kind = (outcome_seq != seq) ? last_kind : 0;
    endtask

    initial begin
        logic [10:0] frame;
        int          kind;
        int          seq;
        bit          ok;

        rst      = 1'b1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        waitCycles(5);
        rst = 1'b0;
        checkOutput("reset_state", 32'({kclk_oe, kdata_oe, busy, done, err}), 32'h0);
        waitCycles(20);

        sendByte(8'hED, 1'b1, 1'b0, frame, kind);
        checkOutput("frame_ED", 32'(frame), 32'h7DA);
        checkOutput("ED_done", 32'(kind), 32'd1);
        checkOutput("inhibit_len", 32'(last_inh_len), 32'd100);
        waitCycles(20);

        sendByte(8'h01, 1'b1, 1'b0, frame, kind);
        checkOutput("frame_01", 32'(frame), 32'h402);
        checkOutput("01_done", 32'(kind), 32'd1);
        waitCycles(20);

        sendByte(8'h00, 1'b1, 1'b0, frame, kind);
        checkOutput("frame_00", 32'(frame), 32'h600);
        checkOutput("00_done", 32'(kind), 32'd1);
        waitCycles(20);

        sendByte(8'hA7, 1'b1, 1'b0, frame, kind);
        checkOutput("frame_A7", 32'(frame), 32'(expectedFrame(8'hA7)));
        checkOutput("A7_done", 32'(kind), 32'd1);
        waitCycles(20);

        seq = outcome_seq;
        applyStimulus(8'h55);
        waitRts(ok);
        waitOutcome(seq, TO + 500);
        checkOutput("timeout_kind", 32'(last_kind), 32'd2);
        checkOutput("timeout_age", 32'(last_age), 32'd20102);
        waitCycles(20);

        sendByte(8'h3C, 1'b0, 1'b0, frame, kind);
        checkOutput("frame_3C", 32'(frame), 32'(expectedFrame(8'h3C)));
        checkOutput("noack_err", 32'(kind), 32'd2);
        waitCycles(20);

        seq = outcome_seq;
        applyStimulus(8'hED);
        waitRts(ok);
        frame = '0;
        fork
            if (ok) devClockBits(10, 1'b1, 1'b0, frame);
            begin
                waitCycles(HALF * 3);
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                waitCycles(1);
                tx_start = 1'b0;
            end
        join
        waitOutcome(seq, 2000);
        checkOutput("frame_ED_midstart", 32'(frame), 32'h7DA);
        checkOutput("midstart_done", 32'(last_kind), 32'd1);
        waitCycles(20);

        seq = outcome_seq;
        applyStimulus(8'hED);
        waitRts(ok);
        if (ok) devClockBits(4, 1'b0, 1'b0, frame);
        checkOutput("partial_frame_ED", 32'(frame[4:0]), 32'h1A);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("rst_midframe", 32'({kclk_oe, kdata_oe, busy, done, err}), 32'h0);
        waitCycles(100);
        checkOutput("rst_no_outcome", 32'(outcome_seq - seq), 32'd0);

        sendByte(8'hED, 1'b1, 1'b1, frame, kind);
        checkOutput("frame_ED_glitch", 32'(frame), 32'h7DA);
        checkOutput("glitch_done", 32'(kind), 32'd1);
        waitCycles(20);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded 90000 cycles, expected completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
